// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter for the single push port of a FIFO.
// A grant is held until the granted requester ends its burst, or until
// MAX_BURST beats have been pushed. No new burst starts while the FIFO is
// almost full, and the winning requester's index travels with the data.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 16,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          busy_o,
    output logic                          push_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o,
    output logic [ID_WIDTH-1:0]           wr_id_o,
    input  logic                          full_i,
    input  logic                          a_full_i
);

    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   gntIdx_q, gntIdx_d;
    logic [ID_WIDTH-1:0]   rrPtr_q, rrPtr_d;
    logic [CNT_WIDTH-1:0]  beatCnt_q, beatCnt_d;

    logic [ID_WIDTH-1:0]   winIdx;
    logic                  winFound;
    logic                  beat;
    logic                  endOfBurst;

    // Index that lies 'offset' positions above 'base', wrapping at NUM_REQ.
    function automatic logic [ID_WIDTH-1:0] wrapAdd(input logic [ID_WIDTH-1:0] base,
                                                    input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_WIDTH'(sum);
    endfunction

    // Round-robin search: first valid requester starting just above the last winner.
    always_comb begin
        winIdx   = '0;
        winFound = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!winFound && req_valid_i[wrapAdd(rrPtr_q, i)]) begin
                winIdx   = wrapAdd(rrPtr_q, i);
                winFound = 1'b1;
            end
        end
    end

    // A beat is an accepted push; the burst ends on its last beat or at the beat cap.
    always_comb begin
        beat       = (state_q == BURST) && req_valid_i[gntIdx_q] && !full_i;
        endOfBurst = beat && (req_last_i[gntIdx_q] ||
                              (beatCnt_q == CNT_WIDTH'(MAX_BURST - 1)));
    end

    // State register with synchronous reset; requester 0 wins first after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gntIdx_q  <= '0;
            rrPtr_q   <= ID_WIDTH'(NUM_REQ - 1);
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gntIdx_q  <= gntIdx_d;
            rrPtr_q   <= rrPtr_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    // Next-state logic: grant from IDLE unless almost full, count beats in BURST.
    always_comb begin
        state_d   = state_q;
        gntIdx_d  = gntIdx_q;
        rrPtr_d   = rrPtr_q;
        beatCnt_d = beatCnt_q;
        unique case (state_q)
            IDLE: begin
                if (winFound && !a_full_i) begin
                    state_d   = BURST;
                    gntIdx_d  = winIdx;
                    rrPtr_d   = winIdx;
                    beatCnt_d = '0;
                end
            end
            BURST: begin
                if (beat) begin
                    beatCnt_d = beatCnt_q + CNT_WIDTH'(1);
                end
                if (endOfBurst) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: route the granted requester to the FIFO, everything zero in IDLE.
    always_comb begin
        req_ready_o = '0;
        gnt_o       = '0;
        busy_o      = 1'b0;
        push_o      = 1'b0;
        wr_data_o   = '0;
        wr_id_o     = '0;
        if (state_q == BURST) begin
            busy_o                = 1'b1;
            gnt_o[gntIdx_q]       = 1'b1;
            req_ready_o[gntIdx_q] = !full_i;
            push_o                = beat;
            wr_data_o             = req_data_i[int'(gntIdx_q) * DATA_WIDTH +: DATA_WIDTH];
            wr_id_o               = gntIdx_q;
        end
    end

endmodule
